// File: rtl/led_fade_ctrl.sv
// LED brightness sequencer: one-shot fades and continuous breathing, stepped by
// PWM frame ticks at a programmable rate. Brightness is registered for the comparator.
module led_fade_ctrl #(
    parameter int RATE_W = 4
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              frame_tick,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [7:0]        cmd_target,
    input  logic [RATE_W-1:0] cmd_rate,
    input  logic              cmd_breathe,
    output logic [7:0]        brightness,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, FADE, BR_UP, BR_DOWN} state_t;

    localparam logic [RATE_W-1:0] CNT_ONE = 1;

    state_t            state, state_nx;
    logic [7:0]        bright_nx;
    logic [7:0]        lo, lo_nx, hi, hi_nx, target, target_nx;
    logic [7:0]        goal, stepped;
    logic [RATE_W-1:0] rate, rate_nx, cnt, cnt_nx;
    logic              done_nx, accept;

    // One unit toward the goal, never overshooting and never wrapping.
    function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] g);
        if (cur < g)
            return cur + 8'd1;
        else if (cur > g)
            return cur - 8'd1;
        else
            return cur;
    endfunction

    always_comb begin
        cmd_ready = (state != FADE);
        busy      = (state != IDLE);
        accept    = cmd_valid && cmd_ready;

        case (state)
            FADE:    goal = target;
            BR_UP:   goal = hi;
            BR_DOWN: goal = lo;
            default: goal = brightness;
        endcase
        stepped = step_toward(brightness, goal);

        state_nx  = state;
        bright_nx = brightness;
        lo_nx     = lo;
        hi_nx     = hi;
        target_nx = target;
        rate_nx   = rate;
        cnt_nx    = cnt;
        done_nx   = 1'b0;

        if (accept) begin
            // Accept wins over a coincident frame_tick, which is dropped.
            target_nx = cmd_target;
            rate_nx   = cmd_rate;
            cnt_nx    = '0;
            if (cmd_target == brightness) begin
                state_nx = IDLE;
                done_nx  = !cmd_breathe;
            end else if (!cmd_breathe) begin
                state_nx = FADE;
            end else begin
                lo_nx    = (cmd_target < brightness) ? cmd_target : brightness;
                hi_nx    = (cmd_target > brightness) ? cmd_target : brightness;
                state_nx = (cmd_target > brightness) ? BR_UP : BR_DOWN;
            end
        end else if (frame_tick && state != IDLE) begin
            if (cnt == rate) begin
                cnt_nx    = '0;
                bright_nx = stepped;
                case (state)
                    FADE: begin
                        if (stepped == target) begin
                            state_nx = IDLE;
                            done_nx  = 1'b1;
                        end
                    end
                    BR_UP:   if (stepped == hi) state_nx = BR_DOWN;
                    BR_DOWN: if (stepped == lo) state_nx = BR_UP;
                    default: ;
                endcase
            end else begin
                cnt_nx = cnt + CNT_ONE;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state      <= IDLE;
            brightness <= 8'd0;
            lo         <= 8'd0;
            hi         <= 8'd0;
            target     <= 8'd0;
            rate       <= '0;
            cnt        <= '0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            brightness <= bright_nx;
            lo         <= lo_nx;
            hi         <= hi_nx;
            target     <= target_nx;
            rate       <= rate_nx;
            cnt        <= cnt_nx;
            done       <= done_nx;
        end
    end

endmodule

// File: tb/tb_led_fade_ctrl.sv
// Scoreboarded bench for led_fade_ctrl: directed scenarios plus random traffic,
// checked every cycle against a mode/direction reference model.
module tb_led_fade_ctrl;

    localparam int RATE_W = 4;

    logic              sys_clk = 1'b0;
    logic              rst = 1'b1;
    logic              frame_tick = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [7:0]        cmd_target = 8'd0;
    logic [RATE_W-1:0] cmd_rate = '0;
    logic              cmd_breathe = 1'b0;
    logic [7:0]        brightness;
    logic              busy;
    logic              done;

    led_fade_ctrl #(.RATE_W(RATE_W)) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_rate   (cmd_rate),
        .cmd_breathe(cmd_breathe),
        .brightness (brightness),
        .busy       (busy),
        .done       (done)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [7:0] b;
        logic       busy;
        logic       done;
        logic       ready;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   done_seen = 0;

    // Reference model: mode 0 idle, 1 one-shot fade, 2 breathing with direction dir.
    int m_b = 0, m_mode = 0, m_dir = 1, m_lo = 0, m_hi = 0, m_tgt = 0, m_rate = 0, m_cnt = 0;
    bit m_done = 0;

    task automatic model_step(input bit r, input bit ft, input bit cv, input int tg,
                              input int rt, input bit br);
        exp_t e;
        m_done = 0;
        if (r) begin
            m_b = 0; m_mode = 0; m_dir = 1; m_lo = 0; m_hi = 0; m_tgt = 0; m_rate = 0; m_cnt = 0;
        end else if (cv && m_mode != 1) begin
            m_tgt  = tg;
            m_rate = rt;
            m_cnt  = 0;
            if (tg == m_b) begin
                m_mode = 0;
                m_done = !br;
            end else if (!br) begin
                m_mode = 1;
            end else begin
                m_lo   = (tg < m_b) ? tg : m_b;
                m_hi   = (tg > m_b) ? tg : m_b;
                m_mode = 2;
                m_dir  = (tg > m_b) ? 1 : -1;
            end
        end else if (ft && m_mode != 0) begin
            if (m_cnt == m_rate) begin
                m_cnt = 0;
                if (m_mode == 1) begin
                    m_b = m_b + ((m_tgt > m_b) ? 1 : -1);
                    if (m_b == m_tgt) begin
                        m_mode = 0;
                        m_done = 1;
                    end
                end else begin
                    m_b = m_b + m_dir;
                    if (m_b == m_hi || m_b == m_lo) m_dir = -m_dir;
                end
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        e.b     = m_b[7:0];
        e.busy  = (m_mode != 0);
        e.done  = m_done;
        e.ready = (m_mode != 1);
        q.push_back(e);
    endtask

    task automatic cyc(input bit r, input bit ft, input bit cv, input int tg,
                       input int rt, input bit br);
        @(negedge sys_clk);
        rst         = r;
        frame_tick  = ft;
        cmd_valid   = cv;
        cmd_target  = tg[7:0];
        cmd_rate    = rt[RATE_W-1:0];
        cmd_breathe = br;
        model_step(r, ft, cv, tg, rt, br);
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic ticks(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < gap - 1; j++) idle_cyc();
            cyc(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        end
    endtask

    task automatic cmd(input int tg, input int rt, input bit br);
        cyc(1'b0, 1'b0, 1'b1, tg, rt, br);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    // Wait until the monitor has consumed the last pushed expectation.
    task automatic settle();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge sys_clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                if (done === 1'b1) done_seen++;
                if (brightness !== e.b || busy !== e.busy || done !== e.done ||
                    cmd_ready !== e.ready) begin
                    miscompares++;
                    $display("FAIL cycle @%0t: bright=%0d busy=%b done=%b ready=%b, expected bright=%0d busy=%b done=%b ready=%b",
                             $time, brightness, busy, done, cmd_ready, e.b, e.busy, e.done, e.ready);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int d0;
        int t;
        bit r, ft, cv, br;
        int rt;

        do_reset();
        settle();
        chk("reset_brightness", brightness, 0);
        chk("reset_ready", cmd_ready, 1);

        // One-shot 0 -> 3 at rate 0, tick every 10 cycles.
        d0 = done_seen;
        cmd(3, 0, 1'b0);
        ticks(4, 10);
        settle();
        chk("oneshot3_done_count", done_seen - d0, 1);
        chk("oneshot3_brightness", brightness, 3);
        chk("oneshot3_busy", busy, 0);

        // Rate 2 one-shot 0 -> 2 with an ignored command in the middle.
        do_reset();
        cmd(2, 2, 1'b0);
        ticks(4, 5);
        cmd(200, 0, 1'b1);
        ticks(3, 5);
        settle();
        chk("rate2_brightness", brightness, 2);

        // Breathe 0 <-> 4, never done.
        do_reset();
        d0 = done_seen;
        cmd(4, 0, 1'b1);
        ticks(20, 3);
        settle();
        chk("breathe_no_done", done_seen - d0, 0);
        chk("breathe_busy", busy, 1);
        chk("breathe_after20", brightness, 4);

        // Preempt breathing at 2 (rising) with one-shot to 0.
        do_reset();
        cmd(4, 0, 1'b1);
        ticks(10, 3);
        settle();
        chk("breathe_at2", brightness, 2);
        d0 = done_seen;
        cmd(0, 0, 1'b0);
        ticks(3, 3);
        settle();
        chk("preempt_brightness", brightness, 0);
        chk("preempt_done_count", done_seen - d0, 1);

        // Equal-target commands at 5.
        cmd(5, 0, 1'b0);
        ticks(6, 2);
        d0 = done_seen;
        cmd(5, 1, 1'b0);
        idle_cyc();
        settle();
        chk("equal_oneshot_done", done_seen - d0, 1);
        d0 = done_seen;
        cmd(5, 0, 1'b1);
        ticks(2, 2);
        settle();
        chk("equal_breathe_no_done", done_seen - d0, 0);
        chk("equal_breathe_idle", busy, 0);
        chk("equal_brightness", brightness, 5);

        // Reset mid-fade 100 -> 200; tick on accept cycle not counted.
        do_reset();
        cmd(100, 0, 1'b0);
        ticks(100, 2);
        settle();
        chk("reach100", brightness, 100);
        d0 = done_seen;
        cyc(1'b0, 1'b1, 1'b1, 200, 0, 1'b0);
        settle();
        chk("accept_tick_ignored", brightness, 100);
        chk("fade_not_ready", cmd_ready, 0);
        cyc(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
        settle();
        chk("abort_brightness", brightness, 0);
        chk("abort_idle", busy, 0);
        chk("abort_no_done", done_seen - d0, 0);

        // Random traffic with small target offsets to keep fades short.
        for (int i = 0; i < 4000; i++) begin
            r  = ($urandom_range(0, 299) == 0);
            ft = ($urandom_range(0, 3) == 0);
            cv = ($urandom_range(0, 7) == 0);
            br = $urandom_range(0, 1);
            rt = $urandom_range(0, 3);
            t  = m_b + int'($urandom_range(0, 40)) - 20;
            if ($urandom_range(0, 4) == 0) t = m_b;
            if (t < 0) t = 0;
            if (t > 255) t = 255;
            cyc(r, ft, cv, t, rt, br);
        end
        idle_cyc();
        settle();
        chk("queue_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
